beep_tone_drv: RTL
==================

Name: beep_tone_drv

Overview:
Drives a passive buzzer from the level-type `beep` request produced by the beep counter logic in the seg_led top.
- A rising edge on the request starts a burst sequence: REPEAT tone bursts of ON_MS each, separated by OFF_MS of silence.
- During each burst the output is a square wave at TONE_HZ.
- Sits between the beep counter and the buzzer pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
TONE_HZ, 2_000, buzzer square-wave frequency in Hz
ON_MS, 100, length of one tone burst in ms
OFF_MS, 100, silence between bursts in ms
REPEAT, 2, number of bursts per trigger (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
beep_req  input  1  request level from the beep counter; its rising edge triggers a sequence
beep_stop  input  1  synchronous abort pulse
busy  output  1  high while a sequence is playing
buzzer_out  output  1  square wave to the buzzer pin

Behaviour:
- Single clock domain: clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - busy=0, buzzer_out=0, state=IDLE.
  - All counters = 0.
  - Edge-detect register = 0. A request held high through reset does not trigger until it goes low and then high again.
- Derived constants, truncating integer division:
  - HALF = CLK_FREQ/(2*TONE_HZ)
  - ON_CYC = CLK_FREQ/1000*ON_MS
  - OFF_CYC = CLK_FREQ/1000*OFF_MS
- Constraints: HALF>=1, ON_CYC>=1, REPEAT>=1. OFF_CYC=0 means back-to-back bursts with no GAP state.
- Counter widths are $clog2 of each terminal value (+1). No counter ever wraps; each is cleared at its terminal value.
- Edge detect:
  - start = beep_req & ~beep_req_d.
  - beep_req_d is registered every cycle in every state.
- States: IDLE, TONE, GAP.
- IDLE:
  - busy=0, buzzer_out=0.
  - Leaves on a start sampled at edge k: TONE is entered at k+1 with buzzer_out=1, busy=1, burst_cnt=0.
- TONE:
  - Duration is exactly ON_CYC cycles.
  - Half-period counter increments each cycle. When it reaches HALF-1 it clears and buzzer_out toggles.
  - At the end of the burst:
    - If burst_cnt==REPEAT-1, go to IDLE.
    - Otherwise go to GAP (or straight to TONE if OFF_CYC=0) and increment burst_cnt.
  - buzzer_out is forced to 0 on leaving TONE.
- GAP:
  - Duration is exactly OFF_CYC cycles, buzzer_out=0, busy=1.
  - Then TONE, with the half counter cleared and buzzer_out=1 on the first cycle.
- Retrigger: start while busy is ignored. It is neither queued nor does it restart the sequence.
- beep_stop:
  - In TONE or GAP: state becomes IDLE next cycle, buzzer_out=0, busy=0, counters cleared.
  - Simultaneous with start in IDLE: stop wins, no sequence starts.
- Reset mid-sequence: outputs go to 0 immediately (asynchronous). No resume after reset release.
- busy falls in the same cycle that buzzer_out is forced to 0 at the end of the final burst.

Decomposition:
- Package beep_pkg:
  - state enum (IDLE, TONE, GAP)
  - function computing HALF/ON_CYC/OFF_CYC from the parameters
  - localparam width helper
- One sub-module, tone_div:
  - ports: clk, rst_n, en, clr, wave
  - contains the HALF counter and toggle flop
  - wave=1 on the first enabled cycle after clr
- The top holds the FSM, the duration/burst counters and the edge detect.

Test Plan:
All scenarios use CLK_FREQ=1000, TONE_HZ=100, ON_MS=20, OFF_MS=10, REPEAT=2, giving HALF=5, ON_CYC=20, OFF_CYC=10.
1. beep_req 0->1 at edge k -> busy=1 from k+1. buzzer_out 1 for 5 cycles, 0 for 5, 1, 0 (20 cycles). Then 10 cycles of 0. Then a second 20-cycle burst. busy=0 at k+51.
2. beep_req held high for 200 cycles -> exactly one sequence (50 cycles busy). No retrigger until beep_req falls and rises again.
3. New rising edge at k+15, mid-burst -> ignored. busy still falls at k+51 and total toggles are unchanged.
4. beep_stop pulse at k+25, in GAP -> busy=0 and buzzer_out=0 at k+26. A later rising edge starts a fresh full sequence.
5. rst_n asserted at k+8 mid-tone -> buzzer_out=0 and busy=0 immediately. After release with beep_req still high -> no sequence starts.
6. REPEAT=1, OFF_MS=0 -> a single 20-cycle burst, busy high for exactly 20 cycles. Separately, start and beep_stop in the same cycle -> busy stays 0.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and constant helpers for the buzzer burst driver.
package beep_pkg;

    // Sequencer states: idle, tone burst, silent gap between bursts.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } beep_state_t;

    // Cycle counts derived from the frequency/time parameters.
    typedef struct packed {
        int half;     // clock cycles per half period of the tone
        int on_cyc;   // clock cycles per burst
        int off_cyc;  // clock cycles per gap (0 = back-to-back bursts)
    } beep_timing_t;

    // Truncating integer arithmetic, evaluated at elaboration time.
    function automatic beep_timing_t calc_timing(int clk_freq, int tone_hz,
                                                 int on_ms, int off_ms);
        beep_timing_t t;
        t.half    = clk_freq / (2 * tone_hz);
        t.on_cyc  = clk_freq / 1000 * on_ms;
        t.off_cyc = clk_freq / 1000 * off_ms;
        return t;
    endfunction

    // Counter width able to hold the given terminal value with headroom.
    function automatic int cnt_width(int term);
        return $clog2(term) + 1;
    endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: toggles wave every HALF enabled cycles.
// A clear forces the next enabled cycle to start high with a fresh count.
module tone_div
    import beep_pkg::*;
#(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wave
);

    localparam int            W    = cnt_width(HALF);
    localparam logic [W-1:0]  LAST = W'(HALF - 1);

    logic [W-1:0] cnt_reg;
    logic         wave_reg;

    // Half-period counter and toggle flop; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            wave_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg  <= '0;
            wave_reg <= 1'b1;
        end else if (en) begin
            if (cnt_reg == LAST) begin
                cnt_reg  <= '0;
                wave_reg <= ~wave_reg;
            end else begin
                cnt_reg  <= cnt_reg + W'(1);
            end
        end
    end

    assign wave = wave_reg;

endmodule

// File: rtl/beep_tone_drv.sv
// Buzzer driver: a rising edge on beep_req plays REPEAT bursts of a
// TONE_HZ square wave, ON_MS long, separated by OFF_MS of silence.
module beep_tone_drv
    import beep_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TONE_HZ  = 2_000,
    parameter int ON_MS    = 100,
    parameter int OFF_MS   = 100,
    parameter int REPEAT   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beep_req,
    input  logic beep_stop,
    output logic busy,
    output logic buzzer_out
);

    localparam beep_timing_t TIM     = calc_timing(CLK_FREQ, TONE_HZ, ON_MS, OFF_MS);
    localparam int           HALF    = TIM.half;
    localparam int           ON_CYC  = TIM.on_cyc;
    localparam int           OFF_CYC = TIM.off_cyc;
    localparam int           DUR_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int           DUR_W   = cnt_width(DUR_MAX);
    localparam int           BURST_W = cnt_width(REPEAT);

    localparam logic [DUR_W-1:0]   ON_LAST  = DUR_W'(ON_CYC - 1);
    localparam logic [DUR_W-1:0]   OFF_LAST = DUR_W'((OFF_CYC > 0) ? OFF_CYC - 1 : 0);
    localparam logic [BURST_W-1:0] REP_LAST = BURST_W'(REPEAT - 1);

    beep_state_t        state_reg, state_next;
    logic [DUR_W-1:0]   dur_reg, dur_next;
    logic [BURST_W-1:0] burst_reg, burst_next;
    logic               beep_req_d_reg;
    logic               arm_reg;
    logic               start;
    logic               div_clr;
    logic               div_en;
    logic               wave;

    // A request already high when reset releases must not count as an
    // edge, so triggering is armed only once the request has been seen low.
    assign start = beep_req & ~beep_req_d_reg & arm_reg;

    // Edge-detect history and arming flag, updated in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_req_d_reg <= 1'b0;
            arm_reg        <= 1'b0;
        end else begin
            beep_req_d_reg <= beep_req;
            arm_reg        <= arm_reg | ~beep_req;
        end
    end

    // State, burst-duration and burst-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dur_reg   <= '0;
            burst_reg <= '0;
        end else begin
            state_reg <= state_next;
            dur_reg   <= dur_next;
            burst_reg <= burst_next;
        end
    end

    // Sequencer next-state logic; the divider is held cleared except
    // during a burst cycle that is not the last one of that burst.
    always_comb begin
        state_next = state_reg;
        dur_next   = dur_reg;
        burst_next = burst_reg;
        div_clr    = 1'b1;
        case (state_reg)
            IDLE: begin
                dur_next   = '0;
                burst_next = '0;
                if (start && !beep_stop) begin
                    state_next = TONE;
                end
            end
            TONE: begin
                if (beep_stop) begin
                    state_next = IDLE;
                    dur_next   = '0;
                    burst_next = '0;
                end else if (dur_reg == ON_LAST) begin
                    dur_next = '0;
                    if (burst_reg == REP_LAST) begin
                        state_next = IDLE;
                        burst_next = '0;
                    end else begin
                        burst_next = burst_reg + BURST_W'(1);
                        state_next = (OFF_CYC == 0) ? TONE : GAP;
                    end
                end else begin
                    dur_next = dur_reg + DUR_W'(1);
                    div_clr  = 1'b0;
                end
            end
            GAP: begin
                if (beep_stop) begin
                    state_next = IDLE;
                    dur_next   = '0;
                    burst_next = '0;
                end else if (dur_reg == OFF_LAST) begin
                    state_next = TONE;
                    dur_next   = '0;
                end else begin
                    dur_next = dur_reg + DUR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                dur_next   = '0;
                burst_next = '0;
            end
        endcase
    end

    assign div_en = (state_reg == TONE);

    tone_div #(
        .HALF (HALF)
    ) u_tone_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .clr   (div_clr),
        .wave  (wave)
    );

    // Outputs decode straight from the state register, so they drop to 0
    // the moment reset asserts and together when a sequence ends.
    assign busy       = (state_reg != IDLE);
    assign buzzer_out = (state_reg == TONE) & wave;

endmodule
